// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and helpers.
// Shared by the timing generator and its counters.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_XW = $clog2(DEF_H_TOTAL);
    localparam int DEF_YW = $clog2(DEF_V_TOTAL);

    // Sync pulse covers [sync_start, sync_end)
    function automatic int sync_start(input int vis, input int front);
        return vis + front;
    endfunction

    function automatic int sync_end(input int vis, input int front, input int sync);
        return vis + front + sync;
    endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Enabled modulo counter; resets to MAX so the first enabled edge wraps to 0.
// wrap_o flags the edge on which the count returns to zero.
module wrap_counter #(
    parameter int MAX   = 799,
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    assign wrap_o  = en_i && (r_count == MAX_V);
    assign count_o = r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= MAX_V;
        end else if (wrap_o) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered sync, blank and strobes.
// Decodes are taken from the next position so every output matches the counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = DEF_H_VISIBLE,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_VISIBLE   = DEF_V_VISIBLE,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE,
    localparam int  H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int  V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int  XW          = $clog2(H_TOTAL),
    localparam int  YW          = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          video_on_o,
    output logic [XW-1:0] pixel_x_o,
    output logic [YW-1:0] pixel_y_o,
    output logic          line_end_o,
    output logic          frame_start_o
);

    localparam logic [XW-1:0] H_MAX  = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_MAX  = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_VIS  = XW'(H_VISIBLE);
    localparam logic [YW-1:0] V_VIS  = YW'(V_VISIBLE);
    localparam logic [XW-1:0] HS_BEG = XW'(sync_start(H_VISIBLE, H_FRONT));
    localparam logic [XW-1:0] HS_END = XW'(sync_end(H_VISIBLE, H_FRONT, H_SYNC));
    localparam logic [YW-1:0] VS_BEG = YW'(sync_start(V_VISIBLE, V_FRONT));
    localparam logic [YW-1:0] VS_END = YW'(sync_end(V_VISIBLE, V_FRONT, V_SYNC));

    logic [XW-1:0] w_h_cnt;
    logic [YW-1:0] w_v_cnt;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [XW-1:0] w_h_nxt;
    logic [YW-1:0] w_v_nxt;

    logic r_hsync;
    logic r_vsync;
    logic r_video_on;
    logic r_line_end;
    logic r_frame_start;

    wrap_counter #(.MAX(H_TOTAL - 1), .WIDTH(XW)) u_h_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (1'b1),
        .count_o (w_h_cnt),
        .wrap_o  (w_h_wrap)
    );

    wrap_counter #(.MAX(V_TOTAL - 1), .WIDTH(YW)) u_v_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (w_h_wrap),
        .count_o (w_v_cnt),
        .wrap_o  (w_v_wrap)
    );

    // Position the counters will hold after this edge
    always_comb begin
        w_h_nxt = w_h_cnt + 1'b1;
        w_v_nxt = w_v_cnt;
        if (w_h_wrap) begin
            w_h_nxt = '0;
            w_v_nxt = w_v_wrap ? '0 : w_v_cnt + 1'b1;
        end
        if (rst_i) begin
            w_h_nxt = H_MAX;
            w_v_nxt = V_MAX;
        end
    end

    always_ff @(posedge clk_i) begin
        r_hsync       <= (w_h_nxt >= HS_BEG && w_h_nxt < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        r_vsync       <= (w_v_nxt >= VS_BEG && w_v_nxt < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        r_video_on    <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
        r_line_end    <= (w_h_nxt == H_MAX);
        r_frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
    end

    assign hsync_o       = r_hsync;
    assign vsync_o       = r_vsync;
    assign video_on_o    = r_video_on;
    assign pixel_x_o     = w_h_cnt;
    assign pixel_y_o     = w_v_cnt;
    assign line_end_o    = r_line_end;
    assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for reset/line timing, two small
// instances (active-low and active-high sync) for frame and mid-frame reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;
    logic rst_s = 1'b1;

    logic       d_hs, d_vs, d_vid, d_le, d_fs;
    logic [9:0] d_x, d_y;
    logic       a_hs, a_vs, a_vid, a_le, a_fs;
    logic [3:0] a_x, a_y;
    logic       b_hs, b_vs, b_vid, b_le, b_fs;
    logic [3:0] b_x, b_y;

    vga_timing_gen u_d (
        .clk_i(clk), .rst_i(rst_d), .hsync_o(d_hs), .vsync_o(d_vs),
        .video_on_o(d_vid), .pixel_x_o(d_x), .pixel_y_o(d_y),
        .line_end_o(d_le), .frame_start_o(d_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1'b0)
    ) u_a (
        .clk_i(clk), .rst_i(rst_s), .hsync_o(a_hs), .vsync_o(a_vs),
        .video_on_o(a_vid), .pixel_x_o(a_x), .pixel_y_o(a_y),
        .line_end_o(a_le), .frame_start_o(a_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1'b1)
    ) u_b (
        .clk_i(clk), .rst_i(rst_s), .hsync_o(b_hs), .vsync_o(b_vs),
        .video_on_o(b_vid), .pixel_x_o(b_x), .pixel_y_o(b_y),
        .line_end_o(b_le), .frame_start_o(b_fs)
    );

    int vecs = 0;
    int errs = 0;
    int dx, dy, sx, sy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            if (errs <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode: {hsync, vsync, video_on, line_end, frame_start}
    function automatic logic [4:0] mdl(
        input int x, input int y,
        input int hv, input int hf, input int hs, input int hb,
        input int vv, input int vf, input int vs, input int vb,
        input logic act
    );
        int ht, vt;
        logic h, v;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        h = (x >= hv + hf && x < hv + hf + hs) ? act : ~act;
        v = (y >= vv + vf && y < vv + vf + vs) ? act : ~act;
        return {h, v, (x < hv && y < vv), (x == ht - 1), (x == 0 && y == 0)};
    endfunction

    task automatic step_def(input logic rst);
        rst_d = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            dx = 799; dy = 524;
        end else if (dx == 799) begin
            dx = 0; dy = (dy == 524) ? 0 : dy + 1;
        end else begin
            dx++;
        end
        chk("def_cycle", {d_x, d_y, d_hs, d_vs, d_vid, d_le, d_fs},
            {10'(dx), 10'(dy), mdl(dx, dy, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)});
    endtask

    task automatic step_small(input logic rst);
        rst_s = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            sx = 14; sy = 11;
        end else if (sx == 14) begin
            sx = 0; sy = (sy == 11) ? 0 : sy + 1;
        end else begin
            sx++;
        end
        chk("lo_cycle", {a_x, a_y, a_hs, a_vs, a_vid, a_le, a_fs},
            {4'(sx), 4'(sy), mdl(sx, sy, 8, 2, 3, 2, 6, 1, 2, 3, 1'b0)});
        chk("hi_cycle", {b_x, b_y, b_hs, b_vs, b_vid, b_le, b_fs},
            {4'(sx), 4'(sy), mdl(sx, sy, 8, 2, 3, 2, 6, 1, 2, 3, 1'b1)});
    endtask

    typedef struct {
        logic       rst;
        int         x;
        int         y;
        logic [4:0] fl;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int hs_n, vid_n, le_n, hs_min, hs_max;
        int vs_n, fs_n, last_fs, last_le;
        logic prev_vs;

        // flags: {hsync, vsync, video_on, line_end, frame_start}
        tbl[0] = '{1'b1, 799, 524, 5'b11010};
        tbl[1] = '{1'b1, 799, 524, 5'b11010};
        tbl[2] = '{1'b1, 799, 524, 5'b11010};
        tbl[3] = '{1'b0, 0,   0,   5'b11101};
        tbl[4] = '{1'b0, 1,   0,   5'b11100};
        tbl[5] = '{1'b0, 2,   0,   5'b11100};

        for (int i = 0; i < 6; i++) begin
            rst_d = tbl[i].rst;
            @(posedge clk);
            #1;
            chk("tbl", {d_x, d_y, d_hs, d_vs, d_vid, d_le, d_fs},
                {10'(tbl[i].x), 10'(tbl[i].y), tbl[i].fl});
        end
        dx = 2; dy = 0;

        // Finish line 0, then measure line 1 in full
        while (dx != 799) step_def(1'b0);
        hs_n = 0; vid_n = 0; le_n = 0; hs_min = 9999; hs_max = -1;
        for (int c = 0; c < 800; c++) begin
            step_def(1'b0);
            if (c == 0) chk("line_wrap", {d_x, d_y}, {10'd0, 10'd1});
            if (!d_hs) begin
                hs_n++;
                if (int'(d_x) < hs_min) hs_min = int'(d_x);
                if (int'(d_x) > hs_max) hs_max = int'(d_x);
            end
            if (d_vid) vid_n++;
            if (d_le) begin
                le_n++;
                chk("le_at_x", d_x, 799);
            end
        end
        chk("hsync_len", hs_n, 96);
        chk("hsync_first", hs_min, 656);
        chk("hsync_last", hs_max, 751);
        chk("video_len", vid_n, 640);
        chk("line_end_cnt", le_n, 1);
        step_def(1'b0);
        chk("next_line", {d_x, d_y}, {10'd0, 10'd2});

        // Small instances have been held in reset throughout
        chk("lo_reset", {a_x, a_y, a_hs, a_vs, a_vid, a_le, a_fs}, {4'd14, 4'd11, 5'b11010});
        chk("hi_reset", {b_x, b_y, b_hs, b_vs, b_vid, b_le, b_fs}, {4'd14, 4'd11, 5'b00010});
        sx = 14; sy = 11;

        vs_n = 0; vid_n = 0; fs_n = 0; le_n = 0;
        last_fs = -1; last_le = -1; prev_vs = 1'b1;
        for (int c = 0; c < 540; c++) begin
            step_small(1'b0);
            if (!a_vs) vs_n++;
            if (a_vid) vid_n++;
            if (!a_vs && prev_vs) chk("vs_edge", {a_x, a_y}, {4'd0, 4'd7});
            prev_vs = a_vs;
            if (a_fs) begin
                fs_n++;
                if (last_fs >= 0) chk("fs_period", c - last_fs, 180);
                else chk("fs_first", c, 0);
                last_fs = c;
            end
            if (a_le) begin
                le_n++;
                if (last_le >= 0) chk("le_period", c - last_le, 15);
                last_le = c;
            end
        end
        chk("vsync_cycles", vs_n, 90);
        chk("video_cycles", vid_n, 144);
        chk("fs_count", fs_n, 3);
        chk("le_count", le_n, 36);

        // Reset while inside the vertical sync pulse
        for (int i = 0; i < 200 && !(sx == 13 && sy == 8); i++) step_small(1'b0);
        chk("mid_pos", {a_x, a_y, a_vs, b_vs}, {4'd13, 4'd8, 1'b0, 1'b1});
        step_small(1'b1);
        chk("mid_rst_lo", {a_x, a_y, a_hs, a_vs, a_vid, a_le, a_fs}, {4'd14, 4'd11, 5'b11010});
        chk("mid_rst_hi", {b_x, b_y, b_hs, b_vs, b_vid, b_le, b_fs}, {4'd14, 4'd11, 5'b00010});
        step_small(1'b0);
        chk("mid_rel_lo", {a_x, a_y, a_hs, a_vs, a_vid, a_le, a_fs}, {4'd0, 4'd0, 5'b11101});
        chk("mid_rel_hi", {b_x, b_y, b_hs, b_vs, b_vid, b_le, b_fs}, {4'd0, 4'd0, 5'b00101});

        // Same mid-frame reset on the full-size instance
        step_def(1'b1);
        chk("def_rst", {d_x, d_y, d_hs, d_vs, d_vid, d_le, d_fs}, {10'd799, 10'd524, 5'b11010});
        step_def(1'b0);
        chk("def_rel", {d_x, d_y, d_fs}, {10'd0, 10'd0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
